varint_encoder: RTL and testbench

//  Downstream consumer of the varint input FIFO (data/index/size lanes) filled by the AXI4 write slave.

---
 rtl/varint_encoder.sv | 122 ++++++++++++
 tb/tb_varint_encoder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/varint_encoder.sv
// Pops 32-bit words from a first-word-fall-through FIFO and emits each value as a protobuf
// base-128 varint on a byte-wide valid/ready stream. Optional build macro: VARINT_ZIGZAG_EN.
module varint_encoder #(
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               varint_in_fifo_empty,
  input  logic [DATA_W-1:0]  varint_in_fifo_data,
  input  logic [INDEX_W-1:0] varint_in_index_data,
  input  logic               varint_in_size_data,
  output logic               varint_in_fifo_pop,
`ifdef VARINT_ZIGZAG_EN
  input  logic               zigzag_mode,
`endif
  output logic [7:0]         out_byte,
  output logic [INDEX_W-1:0] out_index,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_orphan
);

  localparam int VAL_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_WAIT_LO = 3'b010,
    S_EMIT    = 3'b100
  } state_t;

  state_t             state, state_next;
  logic [VAL_W-1:0]   val;
  logic [DATA_W-1:0]  hi;
  logic [INDEX_W-1:0] idx;
  logic               more;
  logic [VAL_W-1:0]   load_val;

  assign more = |val[VAL_W-1:7];

  // Value presented to the shift register when a low/only word is popped.
  always_comb begin
    if (state == S_WAIT_LO) begin
      load_val = {hi, varint_in_fifo_data};
    end else begin
      load_val = {{DATA_W{1'b0}}, varint_in_fifo_data};
    end
`ifdef VARINT_ZIGZAG_EN
    if (zigzag_mode) begin
      if (state != S_WAIT_LO) begin
        load_val = {{DATA_W{varint_in_fifo_data[DATA_W-1]}}, varint_in_fifo_data};
      end
      load_val = (load_val << 1) ^ {VAL_W{load_val[VAL_W-1]}};
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (!varint_in_fifo_empty) begin
          state_next = varint_in_size_data ? S_WAIT_LO : S_EMIT;
        end
      end
      S_WAIT_LO: begin
        if (!varint_in_fifo_empty && !varint_in_size_data) begin
          state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready && !more) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pop is gated by reset because the reset state itself (IDLE) would otherwise pop.
  always_comb begin
    varint_in_fifo_pop = reset_n && (state != S_EMIT) && !varint_in_fifo_empty;
    out_valid          = (state == S_EMIT);
    out_byte           = out_valid ? {more, val[6:0]} : 8'h00;
    out_last           = out_valid && !more;
    out_index          = idx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val        <= '0;
      hi         <= '0;
      idx        <= '0;
      err_orphan <= 1'b0;
    end else begin
      err_orphan <= 1'b0;
      if (varint_in_fifo_pop) begin
        if (varint_in_size_data) begin
          hi         <= varint_in_fifo_data;
          err_orphan <= (state == S_WAIT_LO);
        end else begin
          val <= load_val;
          idx <= varint_in_index_data;
        end
      end else if (out_valid && out_ready && more) begin
        val <= val >> 7;
      end
    end
  end

endmodule

// File: tb/tb_varint_encoder.sv
// Self-checking bench for varint_encoder: a FIFO model feeds directed words, a scoreboard
// queue holds the expected bytes and is popped on every accepted output byte.
module tb_varint_encoder;

  localparam int DATA_W  = 32;
  localparam int INDEX_W = 10;

  typedef struct packed {
    logic               size;
    logic [INDEX_W-1:0] index;
    logic [DATA_W-1:0]  data;
  } fifo_ent_t;

  typedef struct packed {
    logic [7:0]         b;
    logic               last;
    logic [INDEX_W-1:0] idx;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               varint_in_fifo_empty;
  logic [DATA_W-1:0]  varint_in_fifo_data;
  logic [INDEX_W-1:0] varint_in_index_data;
  logic               varint_in_size_data;
  logic               varint_in_fifo_pop;
  logic [7:0]         out_byte;
  logic [INDEX_W-1:0] out_index;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;
  logic               err_orphan;
`ifdef VARINT_ZIGZAG_EN
  logic               zigzag_mode;
`endif

  fifo_ent_t fifo[$];
  exp_t      sb[$];
  int        total = 0;
  int        bad   = 0;
  int        orphan_cnt = 0;
  bit        pop_at_neg;
  bit        valid_at_neg;

  varint_encoder #(.DATA_W(DATA_W), .INDEX_W(INDEX_W)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .varint_in_fifo_empty (varint_in_fifo_empty),
    .varint_in_fifo_data  (varint_in_fifo_data),
    .varint_in_index_data (varint_in_index_data),
    .varint_in_size_data  (varint_in_size_data),
    .varint_in_fifo_pop   (varint_in_fifo_pop),
`ifdef VARINT_ZIGZAG_EN
    .zigzag_mode          (zigzag_mode),
`endif
    .out_byte             (out_byte),
    .out_index            (out_index),
    .out_last             (out_last),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .err_orphan           (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    if (fifo.size() != 0) begin
      varint_in_fifo_empty = 1'b0;
      varint_in_fifo_data  = fifo[0].data;
      varint_in_index_data = fifo[0].index;
      varint_in_size_data  = fifo[0].size;
    end else begin
      varint_in_fifo_empty = 1'b1;
      varint_in_fifo_data  = '0;
      varint_in_index_data = '0;
      varint_in_size_data  = 1'b0;
    end
  endtask

  task automatic push_word(input logic size, input logic [INDEX_W-1:0] index,
                           input logic [DATA_W-1:0] data);
    fifo.push_back(fifo_ent_t'({size, index, data}));
    drive_fifo();
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic last, input logic [INDEX_W-1:0] idx);
    sb.push_back(exp_t'({b, last, idx}));
  endtask

  // Reference encoder: 7-bit groups, least significant first, continuation bit on all but the last.
  task automatic expect_value(input logic [63:0] v, input logic [INDEX_W-1:0] idx);
    logic [63:0] r;
    bit          cont;
    r = v;
    do begin
      cont = (r >> 7) != 64'd0;
      expect_byte({cont, r[6:0]}, !cont, idx);
      r = r >> 7;
    end while (cont);
  endtask

  // One clock: sample and score at the falling edge, advance the FIFO model after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    pop_at_neg   = varint_in_fifo_pop;
    valid_at_neg = out_valid;
    if (err_orphan) orphan_cnt++;
    chk("pop_during_emit", 64'(out_valid & varint_in_fifo_pop), 64'd0);
    if (out_valid && out_ready) begin
      chk("byte_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_byte", 64'(out_byte), 64'(e.b));
        chk("out_last", 64'(out_last), 64'(e.last));
        chk("out_index", 64'(out_index), 64'(e.idx));
      end
    end
    @(posedge clk);
    #1;
    if (pop_at_neg) begin
      chk("pop_on_empty", 64'(fifo.size() == 0), 64'd0);
      if (fifo.size() != 0) fifo.delete(0);
    end
    drive_fifo();
  endtask

  task automatic drain(input string tag, input bit random_ready);
    int n;
    n = 0;
    while ((sb.size() != 0 || fifo.size() != 0 || out_valid) && n < 2000) begin
      if (random_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    chk(tag, 64'(n < 2000), 64'd1);
  endtask

  initial begin
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [INDEX_W-1:0] r_idx;

    reset_n   = 1'b0;
    out_ready = 1'b0;
`ifdef VARINT_ZIGZAG_EN
    zigzag_mode = 1'b0;
`endif
    drive_fifo();
    repeat (3) @(posedge clk);
    #1;
    // Word waiting in the FIFO while reset is held must not be popped.
    push_word(1'b0, 10'd3, 32'h0000_0001);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_byte", 64'(out_byte), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_pop", 64'(varint_in_fifo_pop), 64'd0);
    chk("rst_err_orphan", 64'(err_orphan), 64'd0);

    // Value 1, index 3: pop at t, single byte 0x01 valid at t+1.
    expect_byte(8'h01, 1'b1, 10'd3);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("v1_pop_t", 64'(pop_at_neg), 64'd1);
    chk("v1_valid_t", 64'(valid_at_neg), 64'd0);
    tick();
    chk("v1_valid_t1", 64'(valid_at_neg), 64'd1);
    drain("v1_drain", 1'b0);

    // 300 with a five-cycle stall on the second byte.
    out_ready = 1'b0;
    push_word(1'b0, 10'd5, 32'h0000_012C);
    expect_byte(8'hAC, 1'b0, 10'd5);
    expect_byte(8'h02, 1'b1, 10'd5);
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_byte", 64'(out_byte), 64'h02);
      chk("stall_last", 64'(out_last), 64'd1);
      chk("stall_pop", 64'(varint_in_fifo_pop), 64'd0);
    end
    out_ready = 1'b1;
    drain("v300_drain", 1'b0);

    // 64-bit all ones: pops at t and t+1, first byte at t+2, ten bytes.
    push_word(1'b1, 10'd7, 32'hFFFF_FFFF);
    push_word(1'b0, 10'd8, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) expect_byte(8'hFF, 1'b0, 10'd8);
    expect_byte(8'h01, 1'b1, 10'd8);
    tick();
    chk("v64_pop_t", 64'(pop_at_neg), 64'd1);
    tick();
    chk("v64_pop_t1", 64'(pop_at_neg), 64'd1);
    chk("v64_valid_t1", 64'(valid_at_neg), 64'd0);
    tick();
    chk("v64_valid_t2", 64'(valid_at_neg), 64'd1);
    drain("v64_drain", 1'b0);

    // Orphaned high word: hi=1 dropped, value is 2<<32 = 0x2_00000000.
    orphan_cnt = 0;
    push_word(1'b1, 10'd1, 32'h0000_0001);
    push_word(1'b1, 10'd2, 32'h0000_0002);
    push_word(1'b0, 10'd9, 32'h0000_0000);
    for (int i = 0; i < 4; i++) expect_byte(8'h80, 1'b0, 10'd9);
    expect_byte(8'h20, 1'b1, 10'd9);
    drain("orphan_drain", 1'b0);
    tick();
    chk("orphan_pulses", 64'(orphan_cnt), 64'd1);

    // High word retained across an empty FIFO in WAIT_LO.
    push_word(1'b1, 10'd4, 32'h1234_5678);
    repeat (4) tick();
    chk("wait_lo_no_valid", 64'(out_valid), 64'd0);
    push_word(1'b0, 10'd6, 32'h9ABC_DEF0);
    expect_value(64'h1234_5678_9ABC_DEF0, 10'd6);
    drain("wait_lo_drain", 1'b0);

    // Group-boundary values, then random traffic with random backpressure.
    push_word(1'b0, 10'd10, 32'h0000_0000);
    expect_byte(8'h00, 1'b1, 10'd10);
    push_word(1'b0, 10'd11, 32'h0000_007F);
    expect_byte(8'h7F, 1'b1, 10'd11);
    push_word(1'b0, 10'd12, 32'h0000_0080);
    expect_byte(8'h80, 1'b0, 10'd12);
    expect_byte(8'h01, 1'b1, 10'd12);
    push_word(1'b0, 10'd13, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) expect_byte(8'hFF, 1'b0, 10'd13);
    expect_byte(8'h0F, 1'b1, 10'd13);
    push_word(1'b1, 10'd0, 32'h8000_0000);
    push_word(1'b0, 10'd14, 32'h0000_0000);
    expect_value(64'h8000_0000_0000_0000, 10'd14);
    for (int i = 0; i < 10; i++) begin
      r_hi  = $urandom;
      r_lo  = $urandom;
      r_idx = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) begin
        push_word(1'b1, 10'd0, r_hi);
        push_word(1'b0, r_idx, r_lo);
        expect_value({r_hi, r_lo}, r_idx);
      end else begin
        push_word(1'b0, r_idx, r_lo);
        expect_value({32'h0, r_lo}, r_idx);
      end
    end
    drain("random_drain", 1'b1);

`ifdef VARINT_ZIGZAG_EN
    // Zigzag: -1 (32-bit) -> 1, -2 (64-bit) -> 3, +1 -> 2.
    zigzag_mode = 1'b1;
    push_word(1'b0, 10'd2, 32'hFFFF_FFFF);
    expect_byte(8'h01, 1'b1, 10'd2);
    push_word(1'b1, 10'd0, 32'hFFFF_FFFF);
    push_word(1'b0, 10'd3, 32'hFFFF_FFFE);
    expect_byte(8'h03, 1'b1, 10'd3);
    push_word(1'b0, 10'd4, 32'h0000_0001);
    expect_byte(8'h02, 1'b1, 10'd4);
    drain("zigzag_drain", 1'b0);
    zigzag_mode = 1'b0;
`endif

    // Reset mid-emit aborts the value and drops out_valid immediately.
    push_word(1'b1, 10'd1, 32'hFFFF_FFFF);
    push_word(1'b0, 10'd1, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) expect_byte(8'hFF, 1'b0, 10'd1);
    expect_byte(8'h01, 1'b1, 10'd1);
    repeat (4) tick();
    chk("mid_emit_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_byte", 64'(out_byte), 64'd0);
    chk("abort_out_last", 64'(out_last), 64'd0);
    sb.delete();
    fifo.delete();
    drive_fifo();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    chk("post_abort_idle", 64'(out_valid), 64'd0);
    push_word(1'b0, 10'd15, 32'h0000_0080);
    expect_value(64'h80, 10'd15);
    drain("post_abort_drain", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
